// File: rtl/id_ex_stage.sv
// id_ex_stage -- decode-to-execute pipeline register of the uMIPS_32 core.
//
// Captures ALU operands, ALU control and write-back tags from the decoder on a
// valid/ready handshake and presents them to the ALU one cycle later. Operand
// values are resolved from the register file, the immediate/shift-amount
// fields, and (optionally) forwarding from the EX and MEM stages. A load-use
// hazard holds the decoder and inserts a bubble.
//
// Build option:
//   FORWARD_EN  defined   -> EX/MEM forwarding plus one-bubble load-use stall.
//               undefined -> no forwarding; a consumer stalls until every
//                            producer of a source it uses has left EX and MEM.
//
// Ports:
//   clk, clrn              clock, asynchronous active-low reset
//   id_valid / id_ready    decoder handshake
//   id_inst, id_ctrl       raw instruction and decoded controls
//                          (ctrl: [3:0] aluc, [4] aluimm, [5] sext, [6] shift,
//                           [7] use_rs, [8] use_rt, [9] wreg, [10] m2reg)
//   id_rn, id_qa, id_qb    destination register, register-file reads
//   flush                  kill the instruction entering or held in EX
//   ex_ready               EX consumes the current outputs this cycle
//   ex_r                   ALU result of the instruction held here
//   mem_wreg/mem_rn/mem_d  MEM-stage write-back tag and value
//   ex_valid, ex_a, ex_b, ex_aluc, ex_st, ex_ctl, ex_rn   registered outputs
//   stall                  load-use hazard active this cycle
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_inst,
  input  logic [10:0]     id_ctrl,
  input  logic [4:0]      id_rn,
  input  logic [XLEN-1:0] id_qa,
  input  logic [XLEN-1:0] id_qb,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic [XLEN-1:0] ex_r,
  input  logic            mem_wreg,
  input  logic [4:0]      mem_rn,
  input  logic [XLEN-1:0] mem_d,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_aluc,
  output logic [XLEN-1:0] ex_st,
  output logic [1:0]      ex_ctl,
  output logic [4:0]      ex_rn,
  output logic            stall
);

  // 16-bit immediate to datapath width, signed or zero extension.
  function automatic logic [XLEN-1:0] ext_imm(input logic [15:0] imm,
                                              input logic        sext);
    logic signed [15:0] simm;
    simm = imm;
    if (sext)
      return {{(XLEN-16){simm[15]}}, imm};
    else
      return {{(XLEN-16){1'b0}}, imm};
  endfunction

  // A producer matches a source only when it writes a non-zero register.
  function automatic logic src_hit(input logic       wr,
                                   input logic [4:0] dst,
                                   input logic [4:0] src);
    return wr && (dst != 5'd0) && (dst == src);
  endfunction

  logic [4:0]      rs_p0, rt_p0, sa_p0;
  logic [15:0]     imm_p0;
  logic [3:0]      aluc_p0;
  logic            aluimm_p0, sext_p0, shift_p0, use_rs_p0, use_rt_p0;
  logic [1:0]      ctl_p0;
  logic            ex_hit_rs_p0, ex_hit_rt_p0, mem_hit_rs_p0, mem_hit_rt_p0;
  logic [XLEN-1:0] fwd_rs_p0, fwd_rt_p0, a_p0, b_p0;
  logic            hazard_p0;

  logic            vld_p1;
  logic [XLEN-1:0] a_p1, b_p1, st_p1;
  logic [3:0]      aluc_p1;
  logic [1:0]      ctl_p1;
  logic [4:0]      rn_p1;

  // ---- p0: decode fields, hazard detection, operand selection ----
  assign rs_p0     = id_inst[25:21];
  assign rt_p0     = id_inst[20:16];
  assign sa_p0     = id_inst[10:6];
  assign imm_p0    = id_inst[15:0];
  assign aluc_p0   = id_ctrl[3:0];
  assign aluimm_p0 = id_ctrl[4];
  assign sext_p0   = id_ctrl[5];
  assign shift_p0  = id_ctrl[6];
  assign use_rs_p0 = id_ctrl[7];
  assign use_rt_p0 = id_ctrl[8];
  assign ctl_p0    = id_ctrl[10:9];

  assign ex_hit_rs_p0  = src_hit(vld_p1 & ctl_p1[0], rn_p1, rs_p0);
  assign ex_hit_rt_p0  = src_hit(vld_p1 & ctl_p1[0], rn_p1, rt_p0);
  assign mem_hit_rs_p0 = src_hit(mem_wreg, mem_rn, rs_p0);
  assign mem_hit_rt_p0 = src_hit(mem_wreg, mem_rn, rt_p0);

`ifdef FORWARD_EN
  logic unused_opcode;
  assign unused_opcode = ^id_inst[31:26];

  // A load in EX has no result yet, so it is skipped here and the stall
  // below covers it; EX takes priority over MEM for the youngest value.
  assign fwd_rs_p0 = (ex_hit_rs_p0 && !ctl_p1[1]) ? ex_r  :
                     mem_hit_rs_p0                ? mem_d : id_qa;
  assign fwd_rt_p0 = (ex_hit_rt_p0 && !ctl_p1[1]) ? ex_r  :
                     mem_hit_rt_p0                ? mem_d : id_qb;

  assign hazard_p0 = id_valid && ctl_p1[1] &&
                     ((use_rs_p0 && ex_hit_rs_p0) || (use_rt_p0 && ex_hit_rt_p0));
`else
  logic unused_inputs;
  assign unused_inputs = ^{id_inst[31:26], ex_r, mem_d};

  assign fwd_rs_p0 = id_qa;
  assign fwd_rt_p0 = id_qb;

  // Without bypass paths any producer of a used source still in EX (load or
  // ALU alike) or in MEM holds the consumer until it has written back.
  assign hazard_p0 = id_valid &&
                     ((use_rs_p0 && (ex_hit_rs_p0 || mem_hit_rs_p0)) ||
                      (use_rt_p0 && (ex_hit_rt_p0 || mem_hit_rt_p0)));
`endif

  assign a_p0 = shift_p0  ? {{(XLEN-5){1'b0}}, sa_p0} : fwd_rs_p0;
  assign b_p0 = aluimm_p0 ? ext_imm(imm_p0, sext_p0)  : fwd_rt_p0;

  assign stall    = hazard_p0;
  assign id_ready = (!vld_p1 || ex_ready) && !hazard_p0;

  // ---- p1: EX-facing pipeline register ----
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vld_p1  <= 1'b0;
      a_p1    <= '0;
      b_p1    <= '0;
      st_p1   <= '0;
      aluc_p1 <= '0;
      ctl_p1  <= '0;
      rn_p1   <= '0;
    end else if (flush) begin
      // Flush wins over a same-cycle handshake: the decoder slot is dropped.
      vld_p1 <= 1'b0;
    end else if (id_valid && id_ready) begin
      vld_p1  <= 1'b1;
      a_p1    <= a_p0;
      b_p1    <= b_p0;
      st_p1   <= fwd_rt_p0;
      aluc_p1 <= aluc_p0;
      ctl_p1  <= ctl_p0;
      rn_p1   <= id_rn;
    end else if (ex_ready || !vld_p1) begin
      // Drain, or a bubble while the decoder is stalled; data is kept.
      vld_p1 <= 1'b0;
    end
  end

  assign ex_valid = vld_p1;
  assign ex_a     = a_p1;
  assign ex_b     = b_p1;
  assign ex_st    = st_p1;
  assign ex_aluc  = aluc_p1;
  assign ex_ctl   = ctl_p1;
  assign ex_rn    = rn_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed instruction sequences, a behavioural
// reference model of the stage checked every falling clock edge, and literal
// expectations for the key scenarios (forwarding, load-use, immediates,
// backpressure/flush, r0 guard, asynchronous reset).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [31:0] id_inst = '0;
  logic [10:0] id_ctrl = '0;
  logic [4:0]  id_rn = '0;
  logic [31:0] id_qa = '0;
  logic [31:0] id_qb = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;
  logic [31:0] ex_r = '0;
  logic        mem_wreg = 1'b0;
  logic [4:0]  mem_rn = '0;
  logic [31:0] mem_d = '0;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_st;
  logic [3:0]  ex_aluc;
  logic [1:0]  ex_ctl;
  logic [4:0]  ex_rn;
  logic        stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .clrn(clrn),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_ctrl(id_ctrl), .id_rn(id_rn),
    .id_qa(id_qa), .id_qb(id_qb),
    .flush(flush), .ex_ready(ex_ready), .ex_r(ex_r),
    .mem_wreg(mem_wreg), .mem_rn(mem_rn), .mem_d(mem_d),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_aluc(ex_aluc),
    .ex_st(ex_st), .ex_ctl(ex_ctl), .ex_rn(ex_rn), .stall(stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [31:0] m_a, m_b, m_st;
  logic [3:0]  m_aluc;
  logic [1:0]  m_ctl;
  logic [4:0]  m_rn;

  function logic in_ex(input logic [4:0] r);
    return m_valid && m_ctl[0] && (m_rn != 5'd0) && (m_rn == r);
  endfunction

  function logic in_mem(input logic [4:0] r);
    return mem_wreg && (mem_rn != 5'd0) && (mem_rn == r);
  endfunction

  function logic [31:0] src_val(input logic [4:0] r, input logic [31:0] q);
`ifdef FORWARD_EN
    if (in_ex(r) && !m_ctl[1]) return ex_r;
    if (in_mem(r)) return mem_d;
`endif
    return q;
  endfunction

  function logic exp_stall();
    logic [4:0] rs, rt;
    rs = id_inst[25:21];
    rt = id_inst[20:16];
`ifdef FORWARD_EN
    return id_valid && m_ctl[1] &&
           ((id_ctrl[7] && in_ex(rs)) || (id_ctrl[8] && in_ex(rt)));
`else
    return id_valid && ((id_ctrl[7] && (in_ex(rs) || in_mem(rs))) ||
                        (id_ctrl[8] && (in_ex(rt) || in_mem(rt))));
`endif
  endfunction

  function logic exp_ready();
    return (!m_valid || ex_ready) && !exp_stall();
  endfunction

  function logic [31:0] exp_a();
    if (id_ctrl[6]) return 32'(id_inst[10:6]);
    return src_val(id_inst[25:21], id_qa);
  endfunction

  function logic [31:0] exp_b();
    if (id_ctrl[4])
      return id_ctrl[5] ? 32'($signed(id_inst[15:0])) : 32'(id_inst[15:0]);
    return src_val(id_inst[20:16], id_qb);
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_valid <= 1'b0; m_a <= '0; m_b <= '0; m_st <= '0;
      m_aluc <= '0; m_ctl <= '0; m_rn <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (id_valid && exp_ready()) begin
      m_valid <= 1'b1;
      m_a     <= exp_a();
      m_b     <= exp_b();
      m_st    <= src_val(id_inst[20:16], id_qb);
      m_aluc  <= id_ctrl[3:0];
      m_ctl   <= id_ctrl[10:9];
      m_rn    <= id_rn;
    end else if (ex_ready || !m_valid) begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_a", ex_a, m_a);
    chk("ex_b", ex_b, m_b);
    chk("ex_st", ex_st, m_st);
    chk("ex_aluc", 32'(ex_aluc), 32'(m_aluc));
    chk("ex_ctl", 32'(ex_ctl), 32'(m_ctl));
    chk("ex_rn", 32'(ex_rn), 32'(m_rn));
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("id_ready", 32'(id_ready), 32'(exp_ready()));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [10:0] ctl(input logic [3:0] aluc, input logic aluimm,
                                      input logic sext, input logic shift,
                                      input logic urs, input logic urt,
                                      input logic wreg, input logic m2reg);
    return {m2reg, wreg, urt, urs, shift, sext, aluimm, aluc};
  endfunction

  function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  task automatic present(input logic [31:0] inst, input logic [10:0] c,
                         input logic [4:0] rn, input logic [31:0] qa,
                         input logic [31:0] qb);
    id_valid = 1'b1; id_inst = inst; id_ctrl = c;
    id_rn = rn; id_qa = qa; id_qb = qb;
  endtask

  // Advance one clock; the MEM stage inputs follow whatever left EX.
  task automatic step();
    logic       nw;
    logic [4:0] nr;
    nw = m_valid && ex_ready && !flush && m_ctl[0];
    nr = m_rn;
    @(posedge clk);
    #1;
    mem_wreg = nw;
    mem_rn   = nr;
  endtask

  // Hold the presented instruction until accepted; report cycles waited.
  task automatic issue(output int waits);
    waits = 0;
    #1;
    while (!id_ready && waits < 8) begin
      waits++;
      step();
      #1;
    end
    chk("issue_accept", 32'(id_ready), 32'd1);
    step();
    id_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    #1 clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_a", ex_a, 32'd0);
    chk("rst_ready", 32'(id_ready), 32'd1);

    // Immediates and shift, issued back to back.
    present(ins(5'd9, 5'd0, 16'h8000), ctl(4'd2, 1, 1, 0, 1, 0, 1, 0), 5'd8, 32'h5, 32'h0);
    issue(w);
    chk("addi_wait", w, 0);
    chk("addi_b", ex_b, 32'hFFFF8000);
    chk("addi_a", ex_a, 32'h5);
    present(ins(5'd10, 5'd0, 16'h8000), ctl(4'd5, 1, 0, 0, 1, 0, 1, 0), 5'd13, 32'h6, 32'h0);
    issue(w);
    chk("ori_wait", w, 0);
    chk("ori_b", ex_b, 32'h00008000);
    present(ins(5'd0, 5'd11, {5'd14, 5'd3, 6'd0}), ctl(4'd3, 0, 0, 1, 0, 1, 1, 0), 5'd14, 32'h99, 32'h1);
    issue(w);
    chk("sll_wait", w, 0);
    chk("sll_a", ex_a, 32'h3);
    chk("sll_b", ex_b, 32'h1);
    step(); step();

    // ALU-ALU dependence on r5.
    present(ins(5'd3, 5'd4, 16'h0), ctl(4'd2, 0, 0, 0, 1, 1, 1, 0), 5'd5, 32'h1, 32'h2);
    issue(w);
    ex_r = 32'h10;
    present(ins(5'd5, 5'd1, 16'h0), ctl(4'd2, 0, 0, 0, 1, 1, 1, 0), 5'd6, 32'hDEADBEEF, 32'h7);
    #1;
`ifdef FORWARD_EN
    chk("fwd_stall", 32'(stall), 32'd0);
    issue(w);
    chk("fwd_wait", w, 0);
    chk("fwd_a", ex_a, 32'h00000010);
`else
    chk("fwd_stall", 32'(stall), 32'd1);
    issue(w);
    chk("fwd_wait", w, 2);
    chk("fwd_a", ex_a, 32'hDEADBEEF);
`endif
    chk("fwd_b", ex_b, 32'h7);
    step(); step();

    // Load-use on r5.
    present(ins(5'd2, 5'd0, 16'h4), ctl(4'd2, 1, 1, 0, 1, 0, 1, 1), 5'd5, 32'h100, 32'h0);
    issue(w);
    ex_r  = 32'h00000BAD;
    mem_d = 32'h12345678;
    present(ins(5'd5, 5'd2, 16'h0), ctl(4'd6, 0, 0, 0, 1, 1, 1, 0), 5'd7, 32'hDEADBEEF, 32'h3);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_ready", 32'(id_ready), 32'd0);
    issue(w);
`ifdef FORWARD_EN
    chk("lu_wait", w, 1);
    chk("lu_a", ex_a, 32'h12345678);
`else
    chk("lu_wait", w, 2);
    chk("lu_a", ex_a, 32'hDEADBEEF);
`endif
    chk("lu_b", ex_b, 32'h3);
    chk("lu_aluc", 32'(ex_aluc), 32'd6);
    step(); step();

    // Backpressure for three cycles, then flush with id_ready high.
    present(ins(5'd3, 5'd4, 16'h0), ctl(4'd2, 0, 0, 0, 1, 1, 1, 0), 5'd9, 32'hA, 32'hB);
    issue(w);
    ex_ready = 1'b0;
    present(ins(5'd12, 5'd13, 16'h0), ctl(4'd2, 0, 0, 0, 1, 1, 1, 0), 5'd10, 32'h55, 32'h66);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(id_ready), 32'd0);
      chk("bp_valid", 32'(ex_valid), 32'd1);
      chk("bp_a", ex_a, 32'hA);
      step();
    end
    ex_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(id_ready), 32'd1);
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_a", ex_a, 32'hA);
    chk("fl_rn", 32'(ex_rn), 32'd9);

    // r0 guard: a load targeting r0 followed by a reader of r0.
    present(ins(5'd3, 5'd4, 16'h0), ctl(4'd2, 1, 1, 0, 1, 0, 1, 1), 5'd0, 32'h1, 32'h0);
    issue(w);
    ex_r  = 32'h00000BAD;
    mem_d = 32'h00000BAD;
    present(ins(5'd0, 5'd0, 16'h0), ctl(4'd2, 0, 0, 0, 1, 1, 1, 0), 5'd15, 32'h77, 32'h88);
    #1;
    chk("r0_stall", 32'(stall), 32'd0);
    issue(w);
    chk("r0_wait", w, 0);
    chk("r0_a", ex_a, 32'h77);
    chk("r0_b", ex_b, 32'h88);

    // Asynchronous reset while an instruction is held.
    present(ins(5'd20, 5'd21, 16'h0), ctl(4'd7, 0, 0, 0, 1, 1, 1, 0), 5'd22, 32'h1234, 32'h5678);
    issue(w);
    chk("pre_rst_valid", 32'(ex_valid), 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_a", ex_a, 32'd0);
    chk("mid_rst_b", ex_b, 32'd0);
    chk("mid_rst_st", ex_st, 32'd0);
    chk("mid_rst_aluc", 32'(ex_aluc), 32'd0);
    chk("mid_rst_ctl", 32'(ex_ctl), 32'd0);
    chk("mid_rst_rn", 32'(ex_rn), 32'd0);
    @(posedge clk);
    #1 clrn = 1'b1;
    chk("post_rst_ready", 32'(id_ready), 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
